// File: rtl/sram_srw_arbiter_2p_pkg.sv
// Shared definitions for the two-client SRAM arbiter: client ids, default widths, request record.
package sram_srw_arbiter_2p_pkg;

  localparam int ADDRESS_WIDTH = 15;
  localparam int DATA_WIDTH    = 32;
  localparam int BE_WIDTH      = DATA_WIDTH / 8;

  localparam logic CLIENT_A = 1'b0;
  localparam logic CLIENT_B = 1'b1;

  typedef struct packed {
    logic                     read_not_write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0]    write_data;
    logic [BE_WIDTH-1:0]      byte_enable;
  } sram_req_t;

  // Reads never drive byte enables towards the SRAM.
  function automatic logic [BE_WIDTH-1:0] issue_write_enable(input sram_req_t req);
    return req.read_not_write ? '0 : req.byte_enable;
  endfunction

endpackage

// File: rtl/sram_srw_arbiter_2p_if.sv
// Client-side request/response bundle for both arbiter clients.
interface sram_srw_arbiter_2p_if #(
  parameter int address_width = 15,
  parameter int data_width    = 32,
  parameter int be_width      = 4
);
  logic                     req_valid_a;
  logic                     req_ready_a;
  logic                     req_read_not_write_a;
  logic [address_width-1:0] req_address_a;
  logic [data_width-1:0]    req_write_data_a;
  logic [be_width-1:0]      req_byte_enable_a;

  logic                     req_valid_b;
  logic                     req_ready_b;
  logic                     req_read_not_write_b;
  logic [address_width-1:0] req_address_b;
  logic [data_width-1:0]    req_write_data_b;
  logic [be_width-1:0]      req_byte_enable_b;

  logic                     resp_valid_a;
  logic                     resp_valid_b;
  logic [data_width-1:0]    resp_data;

  modport master (
    output req_valid_a, req_read_not_write_a, req_address_a, req_write_data_a, req_byte_enable_a,
    output req_valid_b, req_read_not_write_b, req_address_b, req_write_data_b, req_byte_enable_b,
    input  req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_data
  );

  modport slave (
    input  req_valid_a, req_read_not_write_a, req_address_a, req_write_data_a, req_byte_enable_a,
    input  req_valid_b, req_read_not_write_b, req_address_b, req_write_data_b, req_byte_enable_b,
    output req_ready_a, req_ready_b, resp_valid_a, resp_valid_b, resp_data
  );
endinterface

// File: rtl/sram_srw_arbiter_2p_rr_arbiter_2.sv
// Two-way round-robin grant: combinational grant, registered last_grant pointer.
module sram_rr_arbiter_2
  import sram_srw_arbiter_2p_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic valid_a,
  input  logic valid_b,
  output logic grant_a,
  output logic grant_b
);

  logic last_grant;

  // Grants are gated by reset so no handshake can complete while reset is held.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (!reset) begin
      grant_a = valid_a && (!valid_b || last_grant == CLIENT_B);
      grant_b = valid_b && (!valid_a || last_grant == CLIENT_A);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= CLIENT_B;
    end else if (grant_a) begin
      last_grant <= CLIENT_A;
    end else if (grant_b) begin
      last_grant <= CLIENT_B;
    end
  end

endmodule

// File: rtl/sram_srw_arbiter_2p.sv
// Two-client round-robin sequencer in front of a single-port SRAM; registered issue,
// read data returned two cycles after the handshake with a per-client valid strobe.
module sram_srw_arbiter_2p
  import sram_srw_arbiter_2p_pkg::*;
#(
  parameter int address_width = ADDRESS_WIDTH,
  parameter int data_width    = DATA_WIDTH,
  parameter int be_width      = BE_WIDTH
) (
  input  logic                     sram_clock,
  input  logic                     reset,
  sram_srw_arbiter_2p_if.slave     cl,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  output logic [be_width-1:0]      sram_write_enable,
  input  logic [data_width-1:0]    sram_data_out
);

  logic      grant_a;
  logic      grant_b;
  logic      handshake;
  logic      owner;
  sram_req_t req_sel;
  logic [1:0] rd_vld;
  logic [1:0] rd_own;

  sram_rr_arbiter_2 u_arb (
    .clk     (sram_clock),
    .reset   (reset),
    .valid_a (cl.req_valid_a),
    .valid_b (cl.req_valid_b),
    .grant_a (grant_a),
    .grant_b (grant_b)
  );

  assign cl.req_ready_a = grant_a;
  assign cl.req_ready_b = grant_b;
  assign handshake      = grant_a | grant_b;
  assign owner          = grant_b ? CLIENT_B : CLIENT_A;

  always_comb begin
    req_sel.read_not_write = cl.req_read_not_write_a;
    req_sel.address        = cl.req_address_a;
    req_sel.write_data     = cl.req_write_data_a;
    req_sel.byte_enable    = cl.req_byte_enable_a;
    if (grant_b) begin
      req_sel.read_not_write = cl.req_read_not_write_b;
      req_sel.address        = cl.req_address_b;
      req_sel.write_data     = cl.req_write_data_b;
      req_sel.byte_enable    = cl.req_byte_enable_b;
    end
  end

  // Address and data hold between accesses; only select and write enable drop to idle.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      sram_select         <= 1'b0;
      sram_read_not_write <= 1'b1;
      sram_address        <= '0;
      sram_write_data     <= '0;
      sram_write_enable   <= '0;
    end else if (handshake) begin
      sram_select         <= 1'b1;
      sram_read_not_write <= req_sel.read_not_write;
      sram_address        <= req_sel.address;
      sram_write_data     <= req_sel.write_data;
      sram_write_enable   <= issue_write_enable(req_sel);
    end else begin
      sram_select         <= 1'b0;
      sram_write_enable   <= '0;
    end
  end

  // Stage 0 lines up with the select cycle, stage 1 with SRAM data out.
  always_ff @(posedge sram_clock) begin
    if (reset) begin
      rd_vld <= '0;
      rd_own <= '0;
    end else begin
      rd_vld <= {rd_vld[0], handshake & req_sel.read_not_write};
      rd_own <= {rd_own[0], owner};
    end
  end

  assign cl.resp_valid_a = rd_vld[1] && (rd_own[1] == CLIENT_A);
  assign cl.resp_valid_b = rd_vld[1] && (rd_own[1] == CLIENT_B);
  assign cl.resp_data    = sram_data_out;

endmodule

// File: tb/tb_sram_srw_arbiter_2p.sv
// Directed bench for sram_srw_arbiter_2p with a behavioural single-port SRAM.
module tb_sram_srw_arbiter_2p;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_select;
  logic        sram_read_not_write;
  logic [14:0] sram_address;
  logic [31:0] sram_write_data;
  logic [3:0]  sram_write_enable;
  logic [31:0] sram_data_out = '0;
  logic [31:0] mem [0:255];

  int n_tests = 0;
  int n_fail  = 0;

  sram_srw_arbiter_2p_if #(.address_width(15), .data_width(32), .be_width(4)) bus ();

  sram_srw_arbiter_2p dut (
    .sram_clock          (clk),
    .reset               (reset),
    .cl                  (bus),
    .sram_select         (sram_select),
    .sram_read_not_write (sram_read_not_write),
    .sram_address        (sram_address),
    .sram_write_data     (sram_write_data),
    .sram_write_enable   (sram_write_enable),
    .sram_data_out       (sram_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_select) begin
      if (sram_read_not_write) begin
        sram_data_out <= mem[sram_address[7:0]];
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (sram_write_enable[i]) mem[sram_address[7:0]][8*i +: 8] <= sram_write_data[8*i +: 8];
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pattern(input logic [14:0] addr);
    return 32'hC0DE_0000 | {17'd0, addr};
  endfunction

  logic        exp_own [0:11];
  logic [31:0] exp_dat [0:11];
  logic        exp_g;
  int          a_idx;
  int          b_idx;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = pattern(15'(i));
    mem[16] = 32'h0;
    reset = 1'b1;
    bus.req_valid_a = 1'b1; bus.req_read_not_write_a = 1'b1; bus.req_address_a = '0;
    bus.req_write_data_a = '0; bus.req_byte_enable_a = '0;
    bus.req_valid_b = 1'b0; bus.req_read_not_write_b = 1'b1; bus.req_address_b = '0;
    bus.req_write_data_b = '0; bus.req_byte_enable_b = '0;

    // Reset held: no ready even with a valid request, outputs at reset values.
    tick; tick; tick;
    chk("ready_a_in_reset", bus.req_ready_a, 0);
    bus.req_valid_a = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_select", sram_select, 0);
    chk("rst_we", sram_write_enable, 0);
    chk("rst_rnw", sram_read_not_write, 1);
    chk("rst_addr", sram_address, 0);
    chk("rst_wdata", sram_write_data, 0);
    chk("rst_resp_a", bus.resp_valid_a, 0);
    chk("rst_resp_b", bus.resp_valid_b, 0);
    chk("rst_last_grant", dut.u_arb.last_grant, 1);
    for (int i = 0; i < 10; i++) begin
      tick;
      chk("idle_select", sram_select, 0);
    end

    // Full write then read from A.
    tick;
    bus.req_valid_a = 1'b1; bus.req_read_not_write_a = 1'b0; bus.req_address_a = 15'h0010;
    bus.req_write_data_a = 32'hDEADBEEF; bus.req_byte_enable_a = 4'hF;
    #1;
    chk("wr_ready_a", bus.req_ready_a, 1);
    chk("wr_ready_b", bus.req_ready_b, 0);
    tick;
    bus.req_read_not_write_a = 1'b1;
    #1;
    chk("rd_ready_a", bus.req_ready_a, 1);
    chk("wr_select", sram_select, 1);
    chk("wr_rnw", sram_read_not_write, 0);
    chk("wr_addr", sram_address, 15'h0010);
    chk("wr_wdata", sram_write_data, 32'hDEADBEEF);
    chk("wr_we", sram_write_enable, 4'hF);
    tick;
    bus.req_valid_a = 1'b0;
    #1;
    chk("rd_select", sram_select, 1);
    chk("rd_rnw", sram_read_not_write, 1);
    chk("rd_we", sram_write_enable, 0);
    chk("rd_resp_early", bus.resp_valid_a, 0);
    tick;
    chk("rd_resp_a", bus.resp_valid_a, 1);
    chk("rd_resp_b", bus.resp_valid_b, 0);
    chk("rd_data", bus.resp_data, 32'hDEADBEEF);
    chk("rd_idle_select", sram_select, 0);

    // Partial write of the low two bytes.
    bus.req_valid_a = 1'b1; bus.req_read_not_write_a = 1'b0;
    bus.req_write_data_a = 32'h11223344; bus.req_byte_enable_a = 4'h3;
    #1;
    chk("pw_ready_a", bus.req_ready_a, 1);
    tick;
    bus.req_read_not_write_a = 1'b1;
    #1;
    chk("pw_we", sram_write_enable, 4'h3);
    tick;
    bus.req_valid_a = 1'b0;
    tick;
    chk("pw_resp_a", bus.resp_valid_a, 1);
    chk("pw_data", bus.resp_data, 32'hDEAD3344);

    // B alone for 4 cycles, then both for 8 cycles, then drain.
    a_idx = 0;
    b_idx = 0;
    for (int k = 0; k < 14; k++) begin
      tick;
      bus.req_valid_a = (k >= 4) && (k < 12);
      bus.req_valid_b = (k < 12);
      bus.req_read_not_write_a = 1'b1;
      bus.req_read_not_write_b = 1'b1;
      bus.req_address_a = 15'h0030 + 15'(a_idx);
      bus.req_address_b = 15'h0050 + 15'(b_idx);
      if (k == 4) chk("last_grant_after_b", dut.u_arb.last_grant, 1);
      #1;
      if (k < 12) begin
        exp_g = (k < 4) ? 1'b1 : ((k % 2 == 0) ? 1'b0 : 1'b1);
        chk("rr_ready_a", bus.req_ready_a, !exp_g);
        chk("rr_ready_b", bus.req_ready_b, exp_g);
        exp_own[k] = exp_g;
        if (exp_g) begin
          exp_dat[k] = pattern(15'h0050 + 15'(b_idx));
          b_idx++;
        end else begin
          exp_dat[k] = pattern(15'h0030 + 15'(a_idx));
          a_idx++;
        end
      end else begin
        chk("rr_idle_ready_a", bus.req_ready_a, 0);
        chk("rr_idle_ready_b", bus.req_ready_b, 0);
      end
      if (k >= 2) begin
        chk("rr_resp_a", bus.resp_valid_a, !exp_own[k-2]);
        chk("rr_resp_b", bus.resp_valid_b, exp_own[k-2]);
        chk("rr_data", bus.resp_data, exp_dat[k-2]);
      end else begin
        chk("rr_resp_none_a", bus.resp_valid_a, 0);
      end
    end
    tick;
    chk("rr_drain_a", bus.resp_valid_a, 0);
    chk("rr_drain_b", bus.resp_valid_b, 0);

    // Read handshake, then reset the next cycle: response must vanish.
    bus.req_valid_a = 1'b1; bus.req_read_not_write_a = 1'b1; bus.req_address_a = 15'h0030;
    #1;
    chk("mr_ready_a", bus.req_ready_a, 1);
    tick;
    bus.req_valid_a = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_select", sram_select, 1);
    tick;
    reset = 1'b0;
    #1;
    chk("mr_resp_a", bus.resp_valid_a, 0);
    chk("mr_select_after", sram_select, 0);
    chk("mr_rnw", sram_read_not_write, 1);
    chk("mr_addr", sram_address, 0);
    chk("mr_wdata", sram_write_data, 0);
    chk("mr_we", sram_write_enable, 0);
    chk("mr_last_grant", dut.u_arb.last_grant, 1);
    tick;
    chk("mr_resp_a_late", bus.resp_valid_a, 0);
    chk("mr_resp_b_late", bus.resp_valid_b, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
